// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian 32-bit words written to
// instruction memory, XOR-checksum verified; CPU held in reset until a good image lands.
module imem_loader #(
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_data_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [15:0]       words_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHKSUM, S_DONE, S_ERROR
  } state_t;

  // Largest image that fits: 2^ADDR_W words, widened so the compare never overflows.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t      state, state_next;
  logic [15:0] length_q;
  logic [7:0]  chk_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] shift_q;
  logic        accept;
  logic        load_start;
  logic [15:0] len_full;

  // Handshake: a byte moves on any rising edge where byte_valid_i and byte_ready_o are both high.
  assign byte_ready_o = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                        (state == S_DATA)   || (state == S_CHKSUM);
  assign busy_o       = byte_ready_o;
  assign done_o       = (state == S_DONE);
  assign err_o        = (state == S_ERROR);
  assign cpu_rst_o    = (state != S_DONE);
  assign dbg_state_o  = state;
  assign accept       = byte_valid_i && byte_ready_o;
  assign load_start   = start_i && !busy_o;
  assign len_full     = {length_q[15:8], byte_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start_i) state_next = S_LEN_HI;
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > DEPTH) state_next = S_ERROR;
          else if (len_full == 16'd0)   state_next = S_CHKSUM;
          else                          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_cnt_q == 2'd3 && (words_o + 16'd1) == length_q)
          state_next = S_CHKSUM;
      end
      S_CHKSUM: if (accept) state_next = (byte_i == chk_q) ? S_DONE : S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      length_q   <= '0;
      chk_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      words_o    <= '0;
      im_we_o    <= 1'b0;
      im_addr_o  <= BASE_ADDR;
      im_data_o  <= '0;
    end else begin
      im_we_o <= 1'b0;
      if (load_start) begin
        words_o    <= '0;
        chk_q      <= '0;
        byte_cnt_q <= '0;
      end
      if (accept) begin
        case (state)
          S_LEN_HI: length_q[15:8] <= byte_i;
          S_LEN_LO: length_q[7:0]  <= byte_i;
          S_DATA: begin
            chk_q      <= chk_q ^ byte_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              // Word complete: write strobe and count advance on the same edge.
              im_we_o   <= 1'b1;
              im_data_o <= {shift_q, byte_i};
              im_addr_o <= BASE_ADDR + words_o[ADDR_W-1:0];
              words_o   <= words_o + 16'd1;
            end else begin
              shift_q <= {shift_q[15:0], byte_i};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0x00 and 0x10) share one
// stream; writes are scoreboarded against an image model, end states against tables.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, valid;
  logic [7:0]  byte_d;

  logic        ready_a, we_a, cpu_rst_a, busy_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [15:0] words_a;
  logic [2:0]  st_a;
  logic        ready_b, we_b, cpu_rst_b, busy_b, done_b, err_b;
  logic [7:0]  addr_b;
  logic [31:0] data_b;
  logic [15:0] words_b;
  logic [2:0]  st_b;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_i(byte_d), .byte_valid_i(valid),
    .byte_ready_o(ready_a), .im_we_o(we_a), .im_addr_o(addr_a), .im_data_o(data_a),
    .cpu_rst_o(cpu_rst_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
    .words_o(words_a), .dbg_state_o(st_a));

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h10)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_i(byte_d), .byte_valid_i(valid),
    .byte_ready_o(ready_b), .im_we_o(we_b), .im_addr_o(addr_b), .im_data_o(data_b),
    .cpu_rst_o(cpu_rst_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
    .words_o(words_b), .dbg_state_o(st_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [39:0] exp_qa[$];
  logic [39:0] exp_qb[$];
  logic [39:0] ea, eb;
  logic [7:0]  img[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of its expected queue.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (exp_qa.size() == 0) check("unexpected_write_a", {24'h0, addr_a}, 32'hFFFF_FFFF);
      else begin
        ea = exp_qa.pop_front();
        check("wr_addr_a", {24'h0, addr_a}, {24'h0, ea[39:32]});
        check("wr_data_a", data_a, ea[31:0]);
      end
    end
    if (we_b === 1'b1) begin
      if (exp_qb.size() == 0) check("unexpected_write_b", {24'h0, addr_b}, 32'hFFFF_FFFF);
      else begin
        eb = exp_qb.pop_front();
        check("wr_addr_b", {24'h0, addr_b}, {24'h0, eb[39:32]});
        check("wr_data_b", data_b, eb[31:0]);
      end
    end
  end

  // Reference model: word i is bytes 4i..4i+3 big-endian, at (base + i) mod 256.
  task automatic expect_image(input int len);
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
      exp_qa.push_back({8'(i), w});
      exp_qb.push_back({8'(8'h10 + i), w});
    end
  endtask

  function automatic logic [7:0] img_xor();
    logic [7:0] x = 8'h00;
    foreach (img[i]) x ^= img[i];
    return x;
  endfunction

  task automatic build_image(input int len);
    img.delete();
    for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Driver: optional idle gap (with a start pulse inside it when poke is set), then one byte.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int n;
    for (int g = 0; g < gap; g++) begin
      valid = 1'b0;
      start = poke && (g == 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    byte_d = b;
    valid  = 1'b1;
    n = 0;
    while (ready_a !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_timeout", {31'h0, ready_a}, 32'h1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic run_load(input int len, input logic [7:0] chk, input int gap, input bit poke);
    logic [15:0] l16;
    l16 = 16'(len);
    pulse_start();
    send_byte(l16[15:8], gap, 1'b0);
    send_byte(l16[7:0], gap, 1'b0);
    if (len > 256) return;
    foreach (img[i]) send_byte(img[i], gap, poke);
    send_byte(chk, gap, 1'b0);
  endtask

  task automatic check_end(input string name, input bit e_done, input bit e_err, input int e_words);
    check({name, "_done_a"},    32'(done_a),    32'(e_done));
    check({name, "_err_a"},     32'(err_a),     32'(e_err));
    check({name, "_cpu_rst_a"}, 32'(cpu_rst_a), 32'(!e_done));
    check({name, "_busy_a"},    32'(busy_a),    32'h0);
    check({name, "_ready_a"},   32'(ready_a),   32'h0);
    check({name, "_words_a"},   32'(words_a),   32'(e_words));
    check({name, "_done_b"},    32'(done_b),    32'(e_done));
    check({name, "_err_b"},     32'(err_b),     32'(e_err));
    check({name, "_cpu_rst_b"}, 32'(cpu_rst_b), 32'(!e_done));
    check({name, "_words_b"},   32'(words_b),   32'(e_words));
    check({name, "_pending_a"}, 32'(exp_qa.size()), 32'h0);
    check({name, "_pending_b"}, 32'(exp_qb.size()), 32'h0);
    exp_qa.delete();
    exp_qb.delete();
  endtask

  task automatic check_reset(input string name);
    check({name, "_we"},      32'({we_a, we_b}),           32'h0);
    check({name, "_addr_a"},  32'(addr_a),                 32'h00);
    check({name, "_addr_b"},  32'(addr_b),                 32'h10);
    check({name, "_data"},    data_a | data_b,             32'h0);
    check({name, "_cpu_rst"}, 32'({cpu_rst_a, cpu_rst_b}), 32'h3);
    check({name, "_flags"},   32'({busy_a, done_a, err_a, ready_a, busy_b, done_b, err_b, ready_b}), 32'h0);
    check({name, "_words"},   32'(words_a | words_b),      32'h0);
  endtask

  task automatic nominal_bytes();
    logic [63:0] nb;
    nb = 64'h12345678_9ABCDEF0;
    img.delete();
    for (int i = 7; i >= 0; i--) img.push_back(nb[8*i +: 8]);
  endtask

  task automatic push_nominal();
    exp_qa.push_back({8'h00, 32'h12345678});
    exp_qa.push_back({8'h01, 32'h9ABCDEF0});
    exp_qb.push_back({8'h10, 32'h12345678});
    exp_qb.push_back({8'h11, 32'h9ABCDEF0});
  endtask

  typedef struct {
    int len;
    int gap;
    bit poke;
    bit bad;
    bit e_done;
    bit e_err;
    int e_words;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{len: 1,     gap: 0, poke: 0, bad: 0, e_done: 1, e_err: 0, e_words: 1};
    vecs[1] = '{len: 3,     gap: 1, poke: 0, bad: 1, e_done: 0, e_err: 1, e_words: 3};
    vecs[2] = '{len: 256,   gap: 0, poke: 0, bad: 0, e_done: 1, e_err: 0, e_words: 256};
    vecs[3] = '{len: 257,   gap: 0, poke: 0, bad: 0, e_done: 0, e_err: 1, e_words: 0};
    vecs[4] = '{len: 65535, gap: 2, poke: 0, bad: 0, e_done: 0, e_err: 1, e_words: 0};
    vecs[5] = '{len: 5,     gap: 2, poke: 1, bad: 0, e_done: 1, e_err: 0, e_words: 5};
    vecs[6] = '{len: 0,     gap: 1, poke: 0, bad: 1, e_done: 0, e_err: 1, e_words: 0};
    vecs[7] = '{len: 2,     gap: 0, poke: 1, bad: 0, e_done: 1, e_err: 0, e_words: 2};

    rst = 1'b1; start = 1'b0; valid = 1'b0; byte_d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal load from IDLE.
    nominal_bytes(); push_nominal();
    run_load(2, 8'h00, 0, 1'b0);
    check_end("nominal", 1'b1, 1'b0, 2);

    // Bad checksum: both writes still happen.
    nominal_bytes(); push_nominal();
    run_load(2, 8'h5A, 0, 1'b0);
    check_end("bad_chk", 1'b0, 1'b1, 2);

    // Zero length.
    img.delete();
    run_load(0, 8'h00, 0, 1'b0);
    check_end("zero_len", 1'b1, 1'b0, 0);

    // Oversize length 0x0101: error right after the second byte.
    img.delete();
    run_load(257, 8'h00, 0, 1'b0);
    check_end("oversize", 1'b0, 1'b1, 0);

    // Gaps of 3 idle cycles with start pulses mid-load.
    nominal_bytes(); push_nominal();
    run_load(2, 8'h00, 3, 1'b1);
    check_end("gaps", 1'b1, 1'b0, 2);

    // Reset after 6 data bytes: one write only, then reset values.
    nominal_bytes();
    exp_qa.push_back({8'h00, 32'h12345678});
    exp_qb.push_back({8'h10, 32'h12345678});
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(img[i], 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("mid_reset");
    rst = 1'b0;
    check("mid_reset_pending", 32'(exp_qa.size() + exp_qb.size()), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_reset_idle_cpu_rst", 32'({cpu_rst_a, done_a}), 32'h2);
    nominal_bytes(); push_nominal();
    run_load(2, 8'h00, 0, 1'b0);
    check_end("after_reset", 1'b1, 1'b0, 2);

    // Table-driven vectors with random image contents.
    foreach (vecs[v]) begin
      logic [7:0] chk;
      if (vecs[v].len <= 256) build_image(vecs[v].len); else img.delete();
      if (vecs[v].len <= 256) expect_image(vecs[v].len);
      chk = img_xor() ^ (vecs[v].bad ? 8'($urandom_range(1, 255)) : 8'h00);
      run_load(vecs[v].len, chk, vecs[v].gap, vecs[v].poke);
      check_end($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_err, vecs[v].e_words);
    end

    // Randomized loads against the image model.
    for (int r = 0; r < 20; r++) begin
      int len, gap;
      bit bad, fits;
      logic [7:0] chk;
      len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 400)) : int'($urandom_range(0, 10));
      gap  = int'($urandom_range(0, 2));
      bad  = ($urandom_range(0, 3) == 0);
      fits = (len <= 256);
      if (fits) build_image(len); else img.delete();
      if (fits) expect_image(len);
      chk = img_xor() ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
      run_load(len, chk, gap, r[0]);
      check_end($sformatf("rand%0d", r), fits && !bad, !(fits && !bad), fits ? len : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
